// File: rtl/cdbus_pkg.sv
// cdbus shared definitions: receiver state encoding, default divisor width,
// the receive result payload and a small majority-vote helper.
package cdbus_pkg;

   localparam int unsigned DIV_W_DEF = 16;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned IDX_W     = 3;

   typedef enum logic [2:0] {
      WAIT_IDLE = 3'd0,
      IDLE      = 3'd1,
      START     = 3'd2,
      DATA      = 3'd3,
      STOP      = 3'd4
   } rx_state_e;

   typedef struct packed {
      logic [BYTE_W-1:0] data;
      logic              valid;
      logic              err;
   } rx_result_t;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rx_bytes_if.sv
// Receiver-side bundle: bus line and divisor controls in, received byte and
// status strobes out. master drives the line, slave is the receiver.
interface rx_bytes_if #(
   parameter int unsigned DIV_W = cdbus_pkg::DIV_W_DEF
);

   logic             din;
   logic [DIV_W-1:0] div_ls;
   logic [DIV_W-1:0] div_hs;
   logic             sel;
   logic [7:0]       data;
   logic             data_valid;
   logic             err_frame;
   logic             busy;

   modport master (
      output din, div_ls, div_hs, sel,
      input  data, data_valid, err_frame, busy
   );

   modport slave (
      input  din, div_ls, div_hs, sel,
      output data, data_valid, err_frame, busy
   );

endinterface

// File: rtl/rx_line_sync.sv
// Bus line conditioning: 2-flop synchronizer, optional 3-tap majority filter
// (enabled by CD_RX_FILTER_EN) and falling-edge detect on the resulting line.
// All flops reset to the idle level (1) so reset never fakes a start edge.
module rx_line_sync
   import cdbus_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic din,
   output logic line,
   output logic fall
);

   logic [1:0] sync_q;
   logic       din_s;
   logic       line_d_q;

   // Two-stage synchronizer for the asynchronous bus line.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], din};
      end
   end

   assign din_s = sync_q[1];

`ifdef CD_RX_FILTER_EN
   logic [1:0] hist_q;
   logic       filt_q;

   // Majority of the current and two previous synchronized samples.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         hist_q <= 2'b11;
         filt_q <= 1'b1;
      end else begin
         hist_q <= {hist_q[0], din_s};
         filt_q <= maj3(din_s, hist_q[0], hist_q[1]);
      end
   end

   assign line = filt_q;
`else
   assign line = din_s;
`endif

   // Previous line level for edge detection.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         line_d_q <= 1'b1;
      end else begin
         line_d_q <= line;
      end
   end

   // Combinational so the receiver can act in the edge cycle itself.
   assign fall = line_d_q & ~line;

endmodule

// File: rtl/rx_bytes.sv
// cdbus byte receiver: start-bit detect, mid-bit sampling with a selectable
// low/high-speed divisor, LSB-first 8-bit assembly and stop-bit check.
// CD_RX_FILTER_EN adds a majority glitch filter in rx_line_sync.
module rx_bytes
   import cdbus_pkg::*;
#(
   parameter int unsigned DIV_W = DIV_W_DEF
) (
   input  logic     clk,
   input  logic     reset_n,
   rx_bytes_if.slave bus
);

   rx_state_e         state_q, state_d;
   logic [DIV_W-1:0]  cnt_q, cnt_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic [DIV_W-1:0]  div_sel_c;
   logic [IDX_W-1:0]  idx_q, idx_d;
   logic [BYTE_W-1:0] sh_q, sh_d;
   rx_result_t        res_q, res_d;
   logic              busy_q, busy_d;
   logic              line;
   logic              fall;
   logic              strobe_c;

   rx_line_sync u_line_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .din     (bus.din),
      .line    (line),
      .fall    (fall)
   );

   assign div_sel_c = bus.sel ? bus.div_hs : bus.div_ls;
   assign strobe_c  = (cnt_q == '0);

   // State, bit timing and result registers.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= WAIT_IDLE;
         cnt_q   <= '0;
         div_q   <= '0;
         idx_q   <= '0;
         sh_q    <= '0;
         res_q   <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         div_q   <= div_d;
         idx_q   <= idx_d;
         sh_q    <= sh_d;
         res_q   <= res_d;
         busy_q  <= busy_d;
      end
   end

   // Next-state, bit counter and result computation.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      div_d      = div_q;
      idx_d      = idx_q;
      sh_d       = sh_q;
      res_d.data  = res_q.data;
      res_d.valid = 1'b0;
      res_d.err   = 1'b0;

      if (state_q == START || state_q == DATA || state_q == STOP) begin
         cnt_d = strobe_c ? div_q : cnt_q - DIV_W'(1);
      end

      case (state_q)
         WAIT_IDLE: begin
            if (line) begin
               state_d = IDLE;
            end
         end
         IDLE: begin
            if (fall) begin
               div_d   = div_sel_c;
               // One less than half a bit: the edge cycle itself counts,
               // putting the start sample h cycles after the edge.
               cnt_d   = DIV_W'((div_sel_c >> 1) - DIV_W'(1));
               state_d = START;
            end
         end
         START: begin
            if (strobe_c) begin
               if (line) begin
                  state_d = IDLE;
               end else begin
                  idx_d   = '0;
                  state_d = DATA;
               end
            end
         end
         DATA: begin
            if (strobe_c) begin
               sh_d[idx_q] = line;
               if (idx_q == IDX_W'(7)) begin
                  state_d = STOP;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
         end
         STOP: begin
            if (strobe_c) begin
               if (line) begin
                  res_d.data  = sh_q;
                  res_d.valid = 1'b1;
                  state_d     = IDLE;
               end else begin
                  // Low stop bit: wait for a high line so a break cannot retrigger.
                  res_d.err = 1'b1;
                  state_d   = WAIT_IDLE;
               end
            end
         end
         default: begin
            state_d = WAIT_IDLE;
         end
      endcase

      busy_d = (state_d != IDLE) && (state_d != WAIT_IDLE);
   end

   assign bus.data       = res_q.data;
   assign bus.data_valid = res_q.valid;
   assign bus.err_frame  = res_q.err;
   assign bus.busy       = busy_q;

endmodule

// File: tb/tb_rx_bytes.sv
// Self-checking bench for rx_bytes: directed bytes on the line, expected
// pulses queued at stimulus time and checked by an independent monitor.
module tb_rx_bytes;

   localparam int unsigned DW = 16;
`ifdef CD_RX_FILTER_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 0;
`endif

   typedef struct {
      bit         is_err;
      logic [7:0] data;
      int         cycle;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset_n;
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   logic [7:0] last_good = 8'h00;
   exp_t       sbq[$];

   rx_bytes_if #(.DIV_W(DW)) bus ();

   rx_bytes #(.DIV_W(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   initial forever #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Pulse lands at E + h + 9P + 1, E = drive cycle + 2 (+2 with filter).
   task automatic push(input bit is_err, input logic [7:0] d, input int n, input int p);
      exp_t e;
      e.is_err = is_err;
      e.data   = d;
      e.cycle  = n + 2 + LAT + (p - 1) / 2 + 9 * p + 1;
      sbq.push_back(e);
   endtask

   task automatic send(input logic [7:0] b, input int p, input int stop_bits, input logic stop_val);
      bus.din = 1'b0;
      tick(p);
      for (int i = 0; i < 8; i++) begin
         bus.din = b[i];
         tick(p);
      end
      bus.din = stop_val;
      tick(p * stop_bits);
   endtask

   task automatic send_exp(input logic [7:0] b, input int p);
      push(1'b0, b, cyc, p);
      last_good = b;
      send(b, p, 1, 1'b1);
   endtask

   // Monitor: every pulse must match the head of the expected queue.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (reset_n === 1'b1 && (bus.data_valid === 1'b1 || bus.err_frame === 1'b1)) begin
            chk("pulse_exclusive", 32'(bus.data_valid & bus.err_frame), 32'd0);
            if (sbq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_pulse: dv=%0b err=%0b data=0x%0h at cycle %0d, none expected",
                        bus.data_valid, bus.err_frame, bus.data, cyc);
            end else begin
               e = sbq.pop_front();
               chk("sb_kind", 32'(bus.err_frame), 32'(e.is_err));
               chk("sb_data", 32'(bus.data), 32'(e.data));
               chk("sb_cycle", 32'(cyc), 32'(e.cycle));
            end
         end
      end
   end

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin : stim
      int n;
      int w;
      reset_n    = 1'b0;
      bus.din    = 1'b1;
      bus.div_ls = 16'd5;
      bus.div_hs = 16'd20;
      bus.sel    = 1'b0;
      tick(3);
      chk("rst_data", 32'(bus.data), 32'h00);
      chk("rst_dv", 32'(bus.data_valid), 32'd0);
      chk("rst_err", 32'(bus.err_frame), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      reset_n = 1'b1;
      tick(10);
      chk("idle_busy", 32'(bus.busy), 32'd0);

      // 0xA5 at 6-clock bits
      send_exp(8'hA5, 6);
      tick(10);

      // 2-cycle glitch: false start, busy high E+1..E+2, low at E+3
      n = cyc;
      bus.din = 1'b0;
      tick(2);
      bus.din = 1'b1;
      tick(LAT + 1);
      chk("glitch_busy_e1", 32'(bus.busy), 32'd1);
      tick(1);
      chk("glitch_busy_e2", 32'(bus.busy), 32'd1);
      tick(1);
      chk("glitch_busy_e3", 32'(bus.busy), 32'd0);
      tick(20);

`ifdef CD_RX_FILTER_EN
      // single-cycle glitch is filtered out entirely
      bus.din = 1'b0;
      tick(1);
      bus.din = 1'b1;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("filt_glitch_busy", 32'(bus.busy), 32'd0);
      end
      tick(10);
`endif

      // 0x3C with stop held low for 20 bits: one err_frame, data unchanged
      push(1'b1, last_good, cyc, 6);
      send(8'h3C, 6, 20, 1'b0);
      chk("break_busy", 32'(bus.busy), 32'd0);
      chk("break_data", 32'(bus.data), 32'hA5);
      bus.din = 1'b1;
      tick(20);
      send_exp(8'h5A, 6);
      tick(10);

      // high speed, back-to-back: pulses 210 clocks apart
      bus.sel = 1'b1;
      tick(5);
      send_exp(8'h00, 21);
      send_exp(8'hFF, 21);
      send_exp(8'h55, 21);
      tick(10);

      // sel changes mid-byte: current byte keeps 6-clock bits
      bus.sel = 1'b0;
      tick(5);
      fork
         send_exp(8'hC3, 6);
         begin
            tick(20);
            bus.sel = 1'b1;
         end
      join
      send_exp(8'h96, 21);
      tick(10);

      // reset during data bit 4
      bus.sel = 1'b0;
      tick(5);
      fork
         send(8'hFF, 6, 1, 1'b1);
         begin
            tick(33);
            chk("pre_reset_busy", 32'(bus.busy), 32'd1);
            reset_n = 1'b0;
            #1;
            chk("mid_reset_data", 32'(bus.data), 32'h00);
            chk("mid_reset_busy", 32'(bus.busy), 32'd0);
            chk("mid_reset_dv", 32'(bus.data_valid), 32'd0);
            chk("mid_reset_err", 32'(bus.err_frame), 32'd0);
            tick(3);
            reset_n = 1'b1;
         end
      join
      last_good = 8'h00;
      tick(10);
      send_exp(8'h81, 6);

      w = 0;
      while (sbq.size() != 0 && w < 3000) begin
         tick(1);
         w++;
      end
      chk("sb_drain", 32'(sbq.size()), 32'd0);
      tick(30);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
